// File: rtl/dma_burst_gen.sv
// DMA burst generator: splits one descriptor into bus requests. Each burst is capped by
// max_burst and, in INCR mode, by the next 4 KB page; FIXED bursts are also capped at 16 beats.
module dma_burst_gen #(
   parameter int ADDR_WIDTH  = 32,
   parameter int DATA_WIDTH  = 32,
   parameter int BYTES_WIDTH = 32,
   localparam int BPB = DATA_WIDTH / 8,
   localparam int SZ  = $clog2(BPB)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start_i,
   input  logic [ADDR_WIDTH-1:0]  addr_i,
   input  logic [BYTES_WIDTH-1:0] num_bytes_i,
   input  logic                   mode_i,
   input  logic [7:0]             max_burst_i,
   input  logic                   abort_i,
   output logic                   req_valid_o,
   input  logic                   req_ready_i,
   output logic [ADDR_WIDTH-1:0]  req_addr_o,
   output logic [7:0]             req_alen_o,
   output logic [2:0]             req_size_o,
   output logic [BPB-1:0]         req_strb_o,
   output logic                   req_mode_o,
   output logic                   busy_o,
   output logic                   done_o,
   output logic                   err_o,
   output logic                   aborted_o,
   output logic [1:0]             dbg_state_o
);

   localparam int CW = (BYTES_WIDTH > 13) ? BYTES_WIDTH : 13;

   typedef enum logic [1:0] {S_IDLE = 2'd0, S_CALC = 2'd1, S_REQ = 2'd2, S_DONE = 2'd3} state_t;
   state_t state, state_nxt;

   logic [ADDR_WIDTH-1:0]  addr_q;
   logic [BYTES_WIDTH-1:0] rem_q;
   logic                   mode_q;
   logic [7:0]             max_q;
   logic                   abort_q;
   logic                   err_q;
   logic [7:0]             alen_q;
   logic [BPB-1:0]         strb_q;
   logic [8:0]             beats_q;
   logic                   last_q;

   logic [BYTES_WIDTH-1:0] rem_beats;
   logic [12:0]            bnd_beats;
   logic [8:0]             max_beats;
   logic [12:0]            limit;
   logic [12:0]            cap;
   logic                   last;
   logic [8:0]             beats;
   logic [BPB-1:0]         strb;
   logic                   misaligned;
   logic                   abort_eff;

   // Shift-then-round keeps the beat count from overflowing at the largest byte count.
   always_comb begin
      rem_beats = (rem_q >> SZ) + BYTES_WIDTH'(rem_q[SZ-1:0] != '0);
      bnd_beats = (13'd4096 - {1'b0, addr_q[11:0]}) >> SZ;
      max_beats = {1'b0, max_q} + 9'd1;
      limit     = mode_q ? 13'd16 : bnd_beats;
      cap       = ({4'b0, max_beats} < limit) ? {4'b0, max_beats} : limit;
      last      = CW'(rem_beats) <= CW'(cap);
      beats     = last ? rem_beats[8:0] : cap[8:0];
      strb      = '1;
      if (last && (rem_q[SZ-1:0] != '0))
         strb = (BPB'(1) << rem_q[SZ-1:0]) - BPB'(1);
   end

   assign misaligned = addr_q[SZ-1:0] != '0;
   assign abort_eff  = abort_q | abort_i;

   // req_valid_o is high only in REQ and stays high, with every req_* field frozen,
   // until req_ready_i is seen high at a rising clock edge; that edge is the handshake.
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: if (start_i) state_nxt = S_CALC;
         S_CALC: state_nxt = (abort_eff || misaligned || rem_q == '0) ? S_DONE : S_REQ;
         S_REQ:  if (req_ready_i) state_nxt = abort_eff ? S_DONE : S_CALC;
         S_DONE: state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= S_IDLE;
         addr_q  <= '0;
         rem_q   <= '0;
         mode_q  <= 1'b0;
         max_q   <= '0;
         abort_q <= 1'b0;
         err_q   <= 1'b0;
         alen_q  <= '0;
         strb_q  <= '0;
         beats_q <= '0;
         last_q  <= 1'b0;
      end else begin
         state <= state_nxt;
         if (state != S_IDLE && abort_i) abort_q <= 1'b1;
         case (state)
            S_IDLE: if (start_i) begin
               addr_q  <= addr_i;
               rem_q   <= num_bytes_i;
               mode_q  <= mode_i;
               max_q   <= max_burst_i;
               abort_q <= 1'b0;
               err_q   <= 1'b0;
            end
            S_CALC: begin
               if (misaligned) err_q <= 1'b1;
               if (state_nxt == S_REQ) begin
                  alen_q  <= 8'(beats - 9'd1);
                  strb_q  <= strb;
                  beats_q <= beats;
                  last_q  <= last;
               end
            end
            S_REQ: if (req_ready_i) begin
               rem_q <= last_q ? '0 : rem_q - (BYTES_WIDTH'(beats_q) << SZ);
               if (!mode_q) addr_q <= addr_q + (ADDR_WIDTH'(beats_q) << SZ);
            end
            default: ;
         endcase
      end
   end

   assign req_valid_o = state == S_REQ;
   assign req_addr_o  = addr_q;
   assign req_alen_o  = alen_q;
   assign req_size_o  = 3'(SZ);
   assign req_strb_o  = strb_q;
   assign req_mode_o  = mode_q;
   assign busy_o      = state != S_IDLE;
   assign done_o      = state == S_DONE;
   assign err_o       = done_o & err_q;
   assign aborted_o   = done_o & abort_q;
   assign dbg_state_o = state;

endmodule

// File: tb/tb_dma_burst_gen.sv
// Directed bench for dma_burst_gen at DATA_WIDTH=32: burst splitting, 4 KB and FIXED caps,
// partial strobes, zero length, misalignment, abort, back-pressure and asynchronous reset.
module tb_dma_burst_gen;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        start_i = 1'b0;
   logic [31:0] addr_i = '0;
   logic [31:0] num_bytes_i = '0;
   logic        mode_i = 1'b0;
   logic [7:0]  max_burst_i = '0;
   logic        abort_i = 1'b0;
   logic        req_ready_i = 1'b1;
   logic        req_valid_o;
   logic [31:0] req_addr_o;
   logic [7:0]  req_alen_o;
   logic [2:0]  req_size_o;
   logic [3:0]  req_strb_o;
   logic        req_mode_o;
   logic        busy_o, done_o, err_o, aborted_o;
   logic [1:0]  dbg_state_o;

   int vec = 0;
   int miss = 0;

   logic [31:0] obs_addr[$];
   logic [7:0]  obs_alen[$];
   logic [3:0]  obs_strb[$];
   logic        obs_mode[$];
   int          obs_cyc[$];
   int          n_bursts;
   int          done_at;
   logic        done_err, done_abt;

   dma_burst_gen dut (
      .clk(clk), .rst(rst), .start_i(start_i), .addr_i(addr_i), .num_bytes_i(num_bytes_i),
      .mode_i(mode_i), .max_burst_i(max_burst_i), .abort_i(abort_i),
      .req_valid_o(req_valid_o), .req_ready_i(req_ready_i), .req_addr_o(req_addr_o),
      .req_alen_o(req_alen_o), .req_size_o(req_size_o), .req_strb_o(req_strb_o),
      .req_mode_o(req_mode_o), .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
      .aborted_o(aborted_o), .dbg_state_o(dbg_state_o)
   );

   always #5 clk = ~clk;

   // Drives start_i for one cycle at a falling edge; the caller is left at cycle 0 of the transfer.
   task automatic launch(input logic [31:0] a, input logic [31:0] n, input logic m,
                         input logic [7:0] mb);
      @(negedge clk);
      start_i = 1'b1; addr_i = a; num_bytes_i = n; mode_i = m; max_burst_i = mb;
   endtask

   // Runs a whole transfer with ready held high, logging each handshake and the done pulse.
   task automatic run_transfer(input logic [31:0] a, input logic [31:0] n, input logic m,
                               input logic [7:0] mb);
      int c;
      obs_addr.delete(); obs_alen.delete(); obs_strb.delete(); obs_mode.delete(); obs_cyc.delete();
      n_bursts = 0; done_at = -1; done_err = 1'bx; done_abt = 1'bx;
      req_ready_i = 1'b1;
      launch(a, n, m, mb);
      c = 0;
      while (c < 200 && done_at < 0) begin
         @(negedge clk);
         c++;
         start_i = 1'b0;
         if (req_valid_o && req_ready_i) begin
            obs_addr.push_back(req_addr_o); obs_alen.push_back(req_alen_o);
            obs_strb.push_back(req_strb_o); obs_mode.push_back(req_mode_o);
            obs_cyc.push_back(c); n_bursts++;
         end
         if (done_o) begin
            done_at = c; done_err = err_o; done_abt = aborted_o;
         end
      end
      if (done_at < 0) begin
         $display("FAIL transfer_timeout: no done_o within 200 cycles for addr %h", a);
         miss++;
      end
      vec++;
      while (obs_addr.size() < 4) begin
         obs_addr.push_back('x); obs_alen.push_back('x); obs_strb.push_back('x);
         obs_mode.push_back(1'bx); obs_cyc.push_back(-1);
      end
   endtask

   task automatic test_reset();
      if (req_valid_o !== 1'b0) begin $display("FAIL rst_valid: got %b want 0", req_valid_o); miss++; end
      vec++;
      if (busy_o !== 1'b0) begin $display("FAIL rst_busy: got %b want 0", busy_o); miss++; end
      vec++;
      if ({done_o, err_o, aborted_o} !== 3'b000) begin
         $display("FAIL rst_done_err_abt: got %b want 000", {done_o, err_o, aborted_o}); miss++;
      end
      vec++;
      if (req_addr_o !== 32'h0) begin $display("FAIL rst_addr: got %h want 0", req_addr_o); miss++; end
      vec++;
      if (req_alen_o !== 8'h0) begin $display("FAIL rst_alen: got %h want 0", req_alen_o); miss++; end
      vec++;
      if (req_size_o !== 3'd2) begin $display("FAIL rst_size: got %0d want 2", req_size_o); miss++; end
      vec++;
      if (req_strb_o !== 4'h0) begin $display("FAIL rst_strb: got %h want 0", req_strb_o); miss++; end
      vec++;
      if (req_mode_o !== 1'b0) begin $display("FAIL rst_mode: got %b want 0", req_mode_o); miss++; end
      vec++;
      if (dbg_state_o !== 2'd0) begin $display("FAIL rst_state: got %0d want 0", dbg_state_o); miss++; end
      vec++;
   endtask

   task automatic test_incr_basic();
      run_transfer(32'h1000, 32'd64, 1'b0, 8'd7);
      if (n_bursts !== 2) begin $display("FAIL incr_count: got %0d want 2", n_bursts); miss++; end
      vec++;
      if (obs_addr[0] !== 32'h1000 || obs_alen[0] !== 8'd7 || obs_strb[0] !== 4'hF) begin
         $display("FAIL incr_b0: got %h/%0d/%h want 1000/7/f", obs_addr[0], obs_alen[0], obs_strb[0]); miss++;
      end
      vec++;
      if (obs_addr[1] !== 32'h1020 || obs_alen[1] !== 8'd7 || obs_strb[1] !== 4'hF) begin
         $display("FAIL incr_b1: got %h/%0d/%h want 1020/7/f", obs_addr[1], obs_alen[1], obs_strb[1]); miss++;
      end
      vec++;
      if (obs_cyc[0] !== 2 || obs_cyc[1] !== 4) begin
         $display("FAIL incr_latency: got %0d,%0d want 2,4", obs_cyc[0], obs_cyc[1]); miss++;
      end
      vec++;
      if (done_at !== 6 || done_err !== 1'b0 || done_abt !== 1'b0) begin
         $display("FAIL incr_done: got cyc %0d err %b abt %b want 6/0/0", done_at, done_err, done_abt); miss++;
      end
      vec++;
      @(negedge clk);
      if (done_o !== 1'b0 || busy_o !== 1'b0) begin
         $display("FAIL incr_done_pulse: got done %b busy %b want 0/0", done_o, busy_o); miss++;
      end
      vec++;
   endtask

   task automatic test_4k_boundary();
      run_transfer(32'h0FF0, 32'd64, 1'b0, 8'd255);
      if (n_bursts !== 2) begin $display("FAIL 4k_count: got %0d want 2", n_bursts); miss++; end
      vec++;
      if (obs_addr[0] !== 32'h0FF0 || obs_alen[0] !== 8'd3) begin
         $display("FAIL 4k_b0: got %h/%0d want ff0/3", obs_addr[0], obs_alen[0]); miss++;
      end
      vec++;
      if (obs_addr[1] !== 32'h1000 || obs_alen[1] !== 8'd11 || obs_strb[1] !== 4'hF) begin
         $display("FAIL 4k_b1: got %h/%0d/%h want 1000/11/f", obs_addr[1], obs_alen[1], obs_strb[1]); miss++;
      end
      vec++;
   endtask

   task automatic test_partial_and_zero();
      run_transfer(32'h0, 32'd10, 1'b0, 8'd7);
      if (n_bursts !== 1 || obs_addr[0] !== 32'h0 || obs_alen[0] !== 8'd2 || obs_strb[0] !== 4'h3) begin
         $display("FAIL partial: got n %0d %h/%0d/%h want 1 0/2/3", n_bursts, obs_addr[0], obs_alen[0],
                  obs_strb[0]); miss++;
      end
      vec++;
      run_transfer(32'h40, 32'd0, 1'b0, 8'd7);
      if (n_bursts !== 0 || done_at !== 2 || done_err !== 1'b0) begin
         $display("FAIL zero_len: got n %0d done cyc %0d err %b want 0/2/0", n_bursts, done_at, done_err);
         miss++;
      end
      vec++;
   endtask

   task automatic test_fixed_and_misaligned();
      run_transfer(32'h200, 32'd128, 1'b1, 8'd255);
      if (n_bursts !== 2) begin $display("FAIL fixed_count: got %0d want 2", n_bursts); miss++; end
      vec++;
      if (obs_addr[0] !== 32'h200 || obs_alen[0] !== 8'd15 || obs_addr[1] !== 32'h200 ||
          obs_alen[1] !== 8'd15) begin
         $display("FAIL fixed_bursts: got %h/%0d %h/%0d want 200/15 200/15", obs_addr[0], obs_alen[0],
                  obs_addr[1], obs_alen[1]); miss++;
      end
      vec++;
      if (obs_mode[0] !== 1'b1 || obs_strb[1] !== 4'hF) begin
         $display("FAIL fixed_mode_strb: got %b/%h want 1/f", obs_mode[0], obs_strb[1]); miss++;
      end
      vec++;
      run_transfer(32'h202, 32'd16, 1'b0, 8'd7);
      if (n_bursts !== 0 || done_at !== 2 || done_err !== 1'b1 || done_abt !== 1'b0) begin
         $display("FAIL misaligned: got n %0d cyc %0d err %b abt %b want 0/2/1/0", n_bursts, done_at,
                  done_err, done_abt); miss++;
      end
      vec++;
   endtask

   task automatic test_abort_stall();
      int quiet;
      req_ready_i = 1'b0;
      launch(32'h1000, 32'd64, 1'b0, 8'd7);
      @(negedge clk);
      start_i = 1'b0;
      for (int c = 2; c <= 6; c++) begin
         @(negedge clk);
         if (req_valid_o !== 1'b1 || req_addr_o !== 32'h1000 || req_alen_o !== 8'd7 ||
             req_strb_o !== 4'hF) begin
            $display("FAIL stall_hold c%0d: got v%b %h/%0d/%h want v1 1000/7/f", c, req_valid_o,
                     req_addr_o, req_alen_o, req_strb_o); miss++;
         end
         vec++;
         abort_i = (c == 3);
         start_i = (c == 4);
         addr_i  = 32'h3000;
         req_ready_i = (c == 6);
      end
      @(negedge clk);
      req_ready_i = 1'b1;
      if (done_o !== 1'b1 || aborted_o !== 1'b1 || err_o !== 1'b0 || req_valid_o !== 1'b0) begin
         $display("FAIL abort_done: got done %b abt %b err %b v %b want 1/1/0/0", done_o, aborted_o,
                  err_o, req_valid_o); miss++;
      end
      vec++;
      quiet = 0;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         if (req_valid_o || busy_o) quiet++;
      end
      if (quiet !== 0) begin $display("FAIL abort_quiet: got %0d active cycles want 0", quiet); miss++; end
      vec++;
   endtask

   task automatic test_abort_last_handshake();
      req_ready_i = 1'b1;
      launch(32'h0, 32'd10, 1'b0, 8'd7);
      @(negedge clk);
      start_i = 1'b0;
      @(negedge clk);
      if (req_valid_o !== 1'b1) begin $display("FAIL last_abort_valid: got %b want 1", req_valid_o); miss++; end
      vec++;
      abort_i = 1'b1;
      @(negedge clk);
      abort_i = 1'b0;
      if (done_o !== 1'b1 || aborted_o !== 1'b1) begin
         $display("FAIL last_abort_done: got done %b abt %b want 1/1", done_o, aborted_o); miss++;
      end
      vec++;
      @(negedge clk);
      if (req_valid_o !== 1'b0 || busy_o !== 1'b0) begin
         $display("FAIL last_abort_idle: got v %b busy %b want 0/0", req_valid_o, busy_o); miss++;
      end
      vec++;
   endtask

   task automatic test_reset_mid_req();
      req_ready_i = 1'b0;
      launch(32'h1000, 32'd64, 1'b0, 8'd7);
      @(negedge clk);
      start_i = 1'b0;
      @(negedge clk);
      if (req_valid_o !== 1'b1) begin $display("FAIL mid_rst_pre: got %b want 1", req_valid_o); miss++; end
      vec++;
      #2 rst = 1'b0;
      #1;
      if (req_valid_o !== 1'b0 || busy_o !== 1'b0 || req_addr_o !== 32'h0 || dbg_state_o !== 2'd0) begin
         $display("FAIL mid_rst: got v %b busy %b addr %h st %0d want 0/0/0/0", req_valid_o, busy_o,
                  req_addr_o, dbg_state_o); miss++;
      end
      vec++;
      @(negedge clk);
      rst = 1'b1;
      req_ready_i = 1'b1;
      @(negedge clk);
      if (req_valid_o !== 1'b0) begin $display("FAIL mid_rst_post: got %b want 0", req_valid_o); miss++; end
      vec++;
   endtask

   task automatic test_back_to_back();
      run_transfer(32'h2000, 32'd7, 1'b0, 8'd0);
      if (n_bursts !== 2 || obs_addr[0] !== 32'h2000 || obs_strb[0] !== 4'hF ||
          obs_addr[1] !== 32'h2004 || obs_alen[1] !== 8'd0 || obs_strb[1] !== 4'h7) begin
         $display("FAIL b2b_a: got n %0d %h/%h %h/%0d/%h want 2 2000/f 2004/0/7", n_bursts, obs_addr[0],
                  obs_strb[0], obs_addr[1], obs_alen[1], obs_strb[1]); miss++;
      end
      vec++;
      run_transfer(32'h3FFC, 32'd8, 1'b0, 8'd15);
      if (n_bursts !== 2 || obs_alen[0] !== 8'd0 || obs_addr[1] !== 32'h4000 || obs_alen[1] !== 8'd0) begin
         $display("FAIL b2b_b: got n %0d %0d %h/%0d want 2 0 4000/0", n_bursts, obs_alen[0], obs_addr[1],
                  obs_alen[1]); miss++;
      end
      vec++;
   endtask

   initial begin
      rst = 1'b0;
      repeat (3) @(negedge clk);
      test_reset();
      rst = 1'b1;
      test_incr_basic();
      test_4k_boundary();
      test_partial_and_zero();
      test_fixed_and_misaligned();
      test_abort_stall();
      test_abort_last_handshake();
      test_reset_mid_req();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
      $finish;
   end

endmodule

// File: doc/dma_burst_gen.md
DMA_BURST_GEN -- requirements
Module: dma_burst_gen

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, meaning address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, meaning bus width in bits (power of 2, >=32); BPB = DATA_WIDTH/8 bytes per beat.
REQ-003 SHALL have parameter BYTES_WIDTH, default 32, meaning descriptor byte-count width.
REQ-004 SHALL have ports: clk  in  1  clock; rst  in  1  reset.
REQ-005 SHALL have: one clock; reset is asynchronous and active-low.
REQ-006 SHALL have ports: start_i  in  1  launch pulse; addr_i  in  ADDR_WIDTH  start address; num_bytes_i  in  BYTES_WIDTH  transfer length; mode_i  in  1  0=INCR, 1=FIXED; max_burst_i  in  8  max beats minus 1.
REQ-007 SHALL have ports: abort_i  in  1  abort request; req_valid_o  out  1; req_ready_i  in  1; req_addr_o  out  ADDR_WIDTH; req_alen_o  out  8; req_size_o  out  3; req_strb_o  out  BPB  last-beat byte strobe; req_mode_o  out  1.
REQ-008 SHALL have ports: busy_o  out  1; done_o  out  1  one-cycle completion pulse; err_o  out  1  misaligned start, valid with done_o; aborted_o  out  1  valid with done_o.

Function
REQ-009 SHALL implement states IDLE, CALC, REQ, DONE.
REQ-010 IDLE: start_i latches addr_i, num_bytes_i, mode_i, max_burst_i; goes to CALC; start_i outside IDLE is ignored.
REQ-011 CALC: if latched addr not BPB-aligned -> DONE with err_o=1; if remaining bytes=0 -> DONE; else compute next burst and go to REQ.
REQ-012 Remaining beats = ceil(remaining_bytes/BPB), computed without overflow at BYTES_WIDTH max value.
REQ-013 INCR burst beats = min(remaining beats, max_burst+1, beats to next 4 KB boundary (4096 - addr[11:0])/BPB).
REQ-014 FIXED burst beats = min(remaining beats, max_burst+1, 16); req_addr_o constant for whole transfer.
REQ-015 req_alen_o = beats-1; req_size_o = log2(BPB); req_mode_o = latched mode.
REQ-016 req_strb_o = all ones unless the burst contains the final beat and remaining_bytes mod BPB != 0, then low (remaining_bytes mod BPB) bits set.
REQ-017 REQ: req_valid_o=1 with all req_* stable until req_valid_o & req_ready_i; valid never deasserts before handshake.
REQ-018 On handshake: remaining_bytes -= min(beats*BPB, remaining_bytes); INCR addr += beats*BPB; go to CALC.
REQ-019 Latency: start_i at cycle N -> first req_valid_o at cycle N+2; each subsequent burst valid 2 cycles after previous handshake.
REQ-020 abort_i (level, sampled any state except IDLE) sets a sticky abort flag; in CALC flag forces DONE; in REQ current request completes handshake first, then DONE.
REQ-021 DONE: done_o=1 for exactly one cycle with err_o/aborted_o valid, then IDLE; busy_o=1 in CALC, REQ, DONE.
REQ-022 Abort and final handshake in same cycle: aborted_o=1, no further requests.
REQ-023 err_o, aborted_o are 0 whenever done_o=0.

Reset
REQ-024 Asserting rst (low) in any state SHALL immediately return to IDLE, abort any pending request with no handshake needed.
REQ-025 Reset values: req_valid_o=0, busy_o=0, done_o=0, err_o=0, aborted_o=0, req_addr_o=0, req_alen_o=0, req_size_o=log2(BPB), req_strb_o=0, req_mode_o=0, abort flag cleared.

Verification (DATA_WIDTH=32)
REQ-026 addr 0x1000, 64 bytes, INCR, max_burst 7, ready=1 -> bursts (0x1000, alen 7, strb 0xF), (0x1020, alen 7, strb 0xF), done_o, err_o=0.
REQ-027 addr 0x0FF0, 64 bytes, INCR, max_burst 255 -> (0x0FF0, alen 3), (0x1000, alen 11); no burst crosses 4 KB.
REQ-028 addr 0x0, 10 bytes, INCR -> single (0x0, alen 2, strb 0x3); 0 bytes -> done_o 2 cycles after start, no req_valid_o.
REQ-029 addr 0x200, 128 bytes, FIXED, max_burst 255 -> two bursts (0x200, alen 15) each; addr 0x202 -> done_o with err_o=1, no requests.
REQ-030 ready held low 5 cycles with abort_i pulsed during wait -> req_* stable, handshake completes, then done_o with aborted_o=1, no further requests; rst low mid-REQ -> req_valid_o=0 immediately.
